c_stage_dcache: RTL and testbench

- Memory (C) stage of the 5-stage RISC-V core.
- Consumes the ac_* execute-stage bundle (pc, write_sel, is_load/is_store/is_wb, ALU_result, ac_data2) and produces the registered cw_* writeback bundle, which also feeds the execute-stage bypass.
- Contains a direct-mapped, one-word-line, write-through, no-write-allocate data cache with a req/ready memory port.
- Drives dcache_stall, which freezes all upstream pipeline registers.

---
 rtl/c_stage_dcache.sv | 135 +++++++++++++
 tb/tb_c_stage_dcache.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/c_stage_dcache.sv
// Memory stage of the 5-stage core: direct-mapped, one-word-line,
// write-through / no-write-allocate data cache feeding the cw_* bundle.
module c_stage_dcache #(
  parameter int IDX_BITS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ac_pc,
  input  logic [4:0]  ac_write_sel,
  input  logic        ac_is_load,
  input  logic        ac_is_store,
  input  logic        ac_is_wb,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ac_data2,
  output logic        dcache_stall,
  output logic [31:0] cw_pc,
  output logic [4:0]  cw_write_sel,
  output logic        cw_is_wb,
  output logic [31:0] cw_result,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  localparam int LINES = 1 << IDX_BITS;
  localparam int TAG_W = 30 - IDX_BITS;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RESP} state_t;

  state_t              state_reg, state_next;
  logic [LINES-1:0]    valid_reg;
  logic [31:0]         data_array [LINES];
  logic [TAG_W-1:0]    tag_array  [LINES];
  logic [31:0]         resp_reg;

  logic [IDX_BITS-1:0] index;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic                is_load;
  logic                is_store;
  logic                fill;
  logic                wr_hit;
  logic [31:0]         load_data;

  assign index    = ALU_result[IDX_BITS+1:2];
  assign tag      = ALU_result[31:IDX_BITS+2];
  assign hit      = valid_reg[index] && (tag_array[index] == tag);
  // A load+store combination is treated as a load.
  assign is_load  = ac_is_load;
  assign is_store = ac_is_store & ~ac_is_load;

  // Request fields come straight from the frozen execute bundle, so they
  // stay stable for the whole transaction without extra registers.
  assign mem_addr  = {ALU_result[31:2], 2'b00};
  assign mem_wdata = ac_data2;

  assign fill   = (state_reg == RD_MISS) && mem_ready;
  assign wr_hit = (state_reg == WR_THRU) && mem_ready && hit;

  // In RESP the filled word is taken from resp_reg; in IDLE a hit reads the array.
  assign load_data = (state_reg == RESP) ? resp_reg : data_array[index];

  // Next-state, stall and memory-request decode.
  always_comb begin
    state_next   = state_reg;
    dcache_stall = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (is_load && !hit) begin
          dcache_stall = 1'b1;
          state_next   = RD_MISS;
        end else if (is_store) begin
          dcache_stall = 1'b1;
          state_next   = WR_THRU;
        end
      end
      RD_MISS: begin
        dcache_stall = 1'b1;
        mem_req      = 1'b1;
        if (mem_ready) state_next = RESP;
      end
      WR_THRU: begin
        dcache_stall = 1'b1;
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        if (mem_ready) state_next = RESP;
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and line valid bits; reset abandons any fill.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      valid_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (fill) valid_reg[index] <= 1'b1;
    end
  end

  // Data/tag arrays and fill buffer; write-through updates only resident lines.
  always_ff @(posedge clock) begin
    if (fill) begin
      data_array[index] <= mem_rdata;
      tag_array[index]  <= tag;
      resp_reg          <= mem_rdata;
    end else if (wr_hit) begin
      data_array[index] <= ac_data2;
    end
  end

  // Writeback bundle: latch when not stalled, inject a bubble while stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cw_pc        <= '0;
      cw_write_sel <= '0;
      cw_is_wb     <= 1'b0;
      cw_result    <= '0;
    end else if (dcache_stall) begin
      cw_is_wb <= 1'b0;
    end else begin
      cw_pc        <= ac_pc;
      cw_write_sel <= ac_write_sel;
      cw_is_wb     <= ac_is_wb;
      cw_result    <= is_load ? load_data : ALU_result;
    end
  end
endmodule

// File: tb/tb_c_stage_dcache.sv
// Directed bench for c_stage_dcache with a latency-programmable memory responder.
module tb_c_stage_dcache;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ac_pc = '0;
  logic [4:0]  ac_write_sel = '0;
  logic        ac_is_load = 1'b0;
  logic        ac_is_store = 1'b0;
  logic        ac_is_wb = 1'b0;
  logic [31:0] ALU_result = '0;
  logic [31:0] ac_data2 = '0;
  logic        dcache_stall;
  logic [31:0] cw_pc;
  logic [4:0]  cw_write_sel;
  logic        cw_is_wb;
  logic [31:0] cw_result;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  int passed = 0;
  int total  = 0;

  // Memory model state
  logic [31:0] tbmem [int];
  int          lat = 3;
  int          req_cnt = 0;

  c_stage_dcache #(.IDX_BITS(4)) dut (
    .clock(clock), .reset(reset),
    .ac_pc(ac_pc), .ac_write_sel(ac_write_sel),
    .ac_is_load(ac_is_load), .ac_is_store(ac_is_store), .ac_is_wb(ac_is_wb),
    .ALU_result(ALU_result), .ac_data2(ac_data2),
    .dcache_stall(dcache_stall),
    .cw_pc(cw_pc), .cw_write_sel(cw_write_sel), .cw_is_wb(cw_is_wb), .cw_result(cw_result),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Responder: raise mem_ready in the lat-th cycle of a request.
  always @(negedge clock) begin
    if (mem_req) begin
      req_cnt = req_cnt + 1;
      if (req_cnt == lat) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          tbmem[int'(mem_addr)] = mem_wdata;
          mem_rdata = 32'h0;
        end else begin
          mem_rdata = tbmem.exists(int'(mem_addr)) ? tbmem[int'(mem_addr)] : 32'hBAD0BAD0;
        end
      end else begin
        mem_ready = 1'b0;
      end
    end else begin
      req_cnt   = 0;
      mem_ready = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
  endtask

  task automatic set_nop();
    ac_is_load = 0; ac_is_store = 0; ac_is_wb = 0;
    ALU_result = 32'h0; ac_write_sel = 0;
  endtask

  // Present a memory op and run through its stall; ends in the first non-stall cycle.
  task automatic do_mem(input logic ld, input logic st, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] sel, input logic [31:0] pc,
                        output int stalls, output logic seen, output logic [31:0] a,
                        output logic we, output logic [31:0] wd, output logic wb_last);
    ac_is_load = ld; ac_is_store = st; ac_is_wb = ld; ALU_result = addr;
    ac_data2 = wdata; ac_write_sel = sel; ac_pc = pc;
    #1;
    stalls = 0; seen = 0; a = 0; we = 0; wd = 0; wb_last = 0;
    while (dcache_stall === 1'b1 && stalls < 40) begin
      if (mem_req === 1'b1 && !seen) begin
        seen = 1; a = mem_addr; we = mem_we; wd = mem_wdata;
      end
      wb_last = cw_is_wb;
      tick();
      stalls++;
    end
    if (stalls >= 40) check("stall_timeout", 32'(stalls), 32'd0);
  endtask

  int          st_n;
  logic        seen, we, wb_last;
  logic [31:0] a, wd;

  initial begin
    tbmem[32'h40] = 32'hCAFEF00D;
    tbmem[32'h80] = 32'h11112222;

    // Reset state
    tick(); tick();
    check("rst_cw_pc", cw_pc, 0);
    check("rst_cw_sel", 32'(cw_write_sel), 0);
    check("rst_cw_wb", 32'(cw_is_wb), 0);
    check("rst_cw_res", cw_result, 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    reset = 0;
    tick();

    // ALU op
    ac_is_wb = 1; ac_write_sel = 5; ALU_result = 32'h1234; ac_pc = 32'h100;
    #1;
    check("alu_stall", 32'(dcache_stall), 0);
    tick();
    check("alu_wb", 32'(cw_is_wb), 1);
    check("alu_sel", 32'(cw_write_sel), 5);
    check("alu_res", cw_result, 32'h1234);
    check("alu_pc", cw_pc, 32'h100);
    set_nop();

    // Cold load from 0x40, ready in third request cycle
    lat = 3;
    do_mem(1, 0, 32'h40, 0, 7, 32'h104, st_n, seen, a, we, wd, wb_last);
    check("cold_stalls", 32'(st_n), 4);
    check("cold_req_seen", 32'(seen), 1);
    check("cold_addr", a, 32'h40);
    check("cold_we", 32'(we), 0);
    check("cold_bubble", 32'(wb_last), 0);
    check("cold_resp_stall", 32'(dcache_stall), 0);
    tick();
    set_nop();
    check("cold_res", cw_result, 32'hCAFEF00D);
    check("cold_wb", 32'(cw_is_wb), 1);
    check("cold_sel", 32'(cw_write_sel), 7);
    tick();
    check("cold_retire_once", 32'(cw_is_wb), 0);

    // Repeat load hits
    do_mem(1, 0, 32'h40, 0, 8, 32'h108, st_n, seen, a, we, wd, wb_last);
    check("hit_stalls", 32'(st_n), 0);
    check("hit_no_req", 32'(mem_req), 0);
    tick();
    set_nop();
    check("hit_res", cw_result, 32'hCAFEF00D);
    check("hit_sel", 32'(cw_write_sel), 8);

    // Store 0x55 to 0x40 (write-through on a resident line)
    lat = 2;
    do_mem(0, 1, 32'h40, 32'h55, 0, 32'h10C, st_n, seen, a, we, wd, wb_last);
    check("st_stalls", 32'(st_n), 3);
    check("st_we", 32'(we), 1);
    check("st_wdata", wd, 32'h55);
    check("st_addr", a, 32'h40);
    tick();
    set_nop();
    check("st_mem_written", tbmem[32'h40], 32'h55);
    do_mem(1, 0, 32'h40, 0, 9, 32'h110, st_n, seen, a, we, wd, wb_last);
    check("st_ld_stalls", 32'(st_n), 0);
    tick();
    set_nop();
    check("st_ld_res", cw_result, 32'h55);

    // Conflict: 0x80 maps to the same line as 0x40
    lat = 1;
    do_mem(1, 0, 32'h80, 0, 10, 32'h114, st_n, seen, a, we, wd, wb_last);
    check("cf_stalls", 32'(st_n), 2);
    check("cf_addr", a, 32'h80);
    tick();
    set_nop();
    check("cf_res", cw_result, 32'h11112222);
    do_mem(1, 0, 32'h40, 0, 11, 32'h118, st_n, seen, a, we, wd, wb_last);
    check("cf_reload_stalls", 32'(st_n), 2);
    tick();
    set_nop();
    check("cf_reload_res", cw_result, 32'h55);

    // Reset during RD_MISS (0x80 not resident now)
    lat = 10;
    ac_is_load = 1; ac_is_wb = 1; ALU_result = 32'h80; ac_write_sel = 12; ac_pc = 32'h11C;
    tick(); tick();
    check("rm_req_before", 32'(mem_req), 1);
    reset = 1;
    #1;
    check("rm_req_drop", 32'(mem_req), 0);
    check("rm_cw_pc", cw_pc, 0);
    check("rm_cw_res", cw_result, 0);
    check("rm_cw_wb", 32'(cw_is_wb), 0);
    check("rm_cw_sel", 32'(cw_write_sel), 0);
    set_nop();
    tick();
    reset = 0;
    tick();
    lat = 1;
    do_mem(1, 0, 32'h40, 0, 13, 32'h120, st_n, seen, a, we, wd, wb_last);
    check("rm_post_stalls", 32'(st_n), 2);
    check("rm_post_seen", 32'(seen), 1);
    tick();
    set_nop();
    check("rm_post_res", cw_result, 32'h55);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
